tape_cuts_tx: RTL and testbench



---
 rtl/tape_cuts_tx.sv | 189 ++++++++++++++++++
 tb/tb_tape_cuts_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tape_cuts_tx.sv
// Atom CUTS cassette modulator: frames bytes (start, 8 data LSB first, stop) into 1200/2400 Hz FSK on cas_out.
// Optional TAPE_CUTS_TX_TURBO_EN build adds a turbo input that runs the bit clock 4x faster (1200 baud).
module tape_cuts_tx #(
    parameter int HALF_TICK   = 8949,
    parameter int LEADER_BITS = 1500,
    parameter int TICK_W      = 14
) (
    input  logic       clk_42,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       cas_out,
    output logic       busy,
    output logic       leader_active
`ifdef TAPE_CUTS_TX_TURBO_EN
    ,
    input  logic       turbo
`endif
);

    // state  | meaning
    // IDLE   | motor off, cas_out low, prescaler parked at 0
    // LEADER | LEADER_BITS mark bits before the first byte
    // MARK   | mark-tone filler while no byte is waiting
    // START  | start bit (0)
    // DATA   | 8 data bits from the shift register, LSB first
    // STOP   | stop bit (1)
    typedef enum logic [2:0] {IDLE, LEADER, MARK, START, DATA, STOP} state_t;

    localparam int LB_W  = (LEADER_BITS > 1) ? $clog2(LEADER_BITS) : 1;
    localparam int CNT_W = (LB_W > 3) ? LB_W : 3;

    state_t            state, state_n;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_n, tick_last;
    logic [3:0]        tick_idx, tick_idx_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [7:0]        hold, hold_n, shreg, shreg_n;
    logic              hold_full, hold_full_n;
    logic              leader_pending, leader_pending_n;
    logic              cas_n, tx_ready_n;
    logic              tick, boundary, bit_val, load;

`ifdef TAPE_CUTS_TX_TURBO_EN
    logic turbo_q;

    // Rate only changes between bit cells so a cell is never mixed-rate.
    always_ff @(posedge clk_42) begin
        if (reset)
            turbo_q <= 1'b0;
        else if (state == IDLE || boundary)
            turbo_q <= turbo;
    end

    assign tick_last = turbo_q ? TICK_W'(HALF_TICK / 4 - 1) : TICK_W'(HALF_TICK - 1);
`else
    assign tick_last = TICK_W'(HALF_TICK - 1);
`endif

    assign tick          = (state != IDLE) && (tick_cnt == tick_last);
    assign boundary      = tick && (tick_idx == 4'd15);
    assign busy          = (state != IDLE);
    assign leader_active = (state == LEADER);

    always_comb begin
        state_n          = state;
        tick_cnt_n       = tick_cnt;
        tick_idx_n       = tick_idx;
        bit_cnt_n        = bit_cnt;
        hold_n           = hold;
        hold_full_n      = hold_full;
        shreg_n          = shreg;
        leader_pending_n = leader_pending;
        cas_n            = cas_out;
        load             = 1'b0;

        case (state)
            START:   bit_val = 1'b0;
            DATA:    bit_val = shreg[0];
            default: bit_val = 1'b1;
        endcase

        if (tx_valid && tx_ready) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
        end

        if (state != IDLE)
            tick_cnt_n = tick ? '0 : tick_cnt + TICK_W'(1);

        // A 0 cell toggles on odd ticks only, giving half the frequency with continuous phase.
        if (tick) begin
            tick_idx_n = tick_idx + 4'd1;
            if (bit_val || tick_idx[0])
                cas_n = ~cas_out;
        end

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n   = leader_pending ? LEADER : MARK;
                    bit_cnt_n = '0;
                end
            end
            LEADER: begin
                if (boundary) begin
                    if (bit_cnt == CNT_W'(LEADER_BITS - 1)) begin
                        leader_pending_n = 1'b0;
                        if (hold_full) load = 1'b1;
                        else           state_n = MARK;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            MARK: begin
                if (boundary && hold_full)
                    load = 1'b1;
            end
            START: begin
                if (boundary) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (boundary) begin
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(7))
                        state_n = STOP;
                end
            end
            STOP: begin
                if (boundary) begin
                    if (hold_full) load = 1'b1;
                    else           state_n = MARK;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            state_n     = START;
            shreg_n     = hold;
            hold_full_n = 1'b0;
        end

        // Motor stop wins over everything: the partial byte and any held byte are dropped.
        if (!enable) begin
            state_n          = IDLE;
            cas_n            = 1'b0;
            tick_cnt_n       = '0;
            tick_idx_n       = '0;
            hold_full_n      = 1'b0;
            leader_pending_n = 1'b1;
        end

        tx_ready_n = enable && !hold_full_n;
    end

    always_ff @(posedge clk_42) begin
        if (reset) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            tick_idx       <= '0;
            bit_cnt        <= '0;
            hold           <= '0;
            hold_full      <= 1'b0;
            shreg          <= '0;
            leader_pending <= 1'b1;
            cas_out        <= 1'b0;
            tx_ready       <= 1'b0;
        end else begin
            state          <= state_n;
            tick_cnt       <= tick_cnt_n;
            tick_idx       <= tick_idx_n;
            bit_cnt        <= bit_cnt_n;
            hold           <= hold_n;
            hold_full      <= hold_full_n;
            shreg          <= shreg_n;
            leader_pending <= leader_pending_n;
            cas_out        <= cas_n;
            tx_ready       <= tx_ready_n;
        end
    end

endmodule

// File: tb/tb_tape_cuts_tx.sv
// Directed bench for tape_cuts_tx with HALF_TICK=8 and LEADER_BITS=2: a bit cell is 128 cycles,
// a 1 shows 16 cas_out edges per cell and a 0 shows 8.
module tb_tape_cuts_tx;

    localparam int HT  = 8;
    localparam int BIT = 16 * HT;

    logic       clk_42 = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       cas_out;
    logic       busy;
    logic       leader_active;
`ifdef TAPE_CUTS_TX_TURBO_EN
    logic       turbo = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    tape_cuts_tx #(.HALF_TICK(HT), .LEADER_BITS(2), .TICK_W(14)) dut (
        .clk_42        (clk_42),
        .reset         (reset),
        .enable        (enable),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .cas_out       (cas_out),
        .busy          (busy),
        .leader_active (leader_active)
`ifdef TAPE_CUTS_TX_TURBO_EN
        ,
        .turbo         (turbo)
`endif
    );

    always #5 clk_42 = ~clk_42;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Counts cas_out edges over one bit cell; caller sits at the negedge just after a boundary edge.
    task automatic count_bit(output int n);
        logic p;
        p = cas_out;
        n = 0;
        repeat (BIT) begin
            @(negedge clk_42);
            if (cas_out !== p) n++;
            p = cas_out;
        end
    endtask

    // bits[i] is the i-th bit on the wire.
    task automatic expect_bits(input string tag, input int nbits, input logic [15:0] bits);
        int c;
        for (int i = 0; i < nbits; i++) begin
            count_bit(c);
            chk(tag, c, bits[i] ? 32'd16 : 32'd8);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 4000) begin
            @(negedge clk_42);
            n++;
        end
        chk("send_wait_bound", n < 4000, 1);
        @(negedge clk_42);
        tx_valid = 1'b0;
        chk("rdy_drop", tx_ready, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk_42);
        chk("rst_cas", cas_out, 0);
        chk("rst_ready", tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_leader", leader_active, 0);

        // Leader straight out of reset.
        reset = 1'b0;
        @(negedge clk_42);
        chk("lead_busy", busy, 1);
        chk("lead_active", leader_active, 1);
        chk("lead_ready", tx_ready, 1);
        expect_bits("leader", 1, 16'b1);
        chk("lead_mid", leader_active, 1);
        expect_bits("leader", 1, 16'b1);
        chk("lead_end", leader_active, 0);
        chk("mark_busy", busy, 1);

        // 0xA5 after one filler bit.
        fork send(8'hA5); join_none
        expect_bits("mark_a5", 1, 16'b1);
        chk("rdy_load_a5", tx_ready, 1);
        expect_bits("frame_a5", 10, 16'b11_0100_1010);

        // 0x00 then 0xFF with no gap.
        fork begin send(8'h00); send(8'hFF); end join_none
        expect_bits("mark_00", 1, 16'b1);
        chk("rdy_load_00", tx_ready, 1);
        expect_bits("frame_00", 10, 16'b10_0000_0000);
        chk("rdy_load_ff", tx_ready, 1);
        expect_bits("frame_ff", 10, 16'b11_1111_1110);

        // Underrun: 0x55, three filler marks, then 0x80.
        fork send(8'h55); join_none
        expect_bits("mark_55", 1, 16'b1);
        expect_bits("frame_55", 10, 16'b10_1010_1010);
        expect_bits("underrun", 2, 16'b11);
        fork send(8'h80); join_none
        expect_bits("underrun", 1, 16'b1);
        chk("no_releader", leader_active, 0);
        expect_bits("frame_80", 10, 16'b11_0000_0000);

        // 0x3C in flight with 0x99 held, then motor stop mid-DATA.
        fork begin send(8'h3C); send(8'h99); end join_none
        expect_bits("mark_3c", 1, 16'b1);
        expect_bits("part_3c", 4, 16'b1000);
        repeat (40) @(negedge clk_42);
        enable = 1'b0;
        @(negedge clk_42);
        chk("off_cas", cas_out, 0);
        chk("off_busy", busy, 0);
        chk("off_ready", tx_ready, 0);
        chk("off_leader", leader_active, 0);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (5) @(negedge clk_42);
        chk("off_ignore", tx_ready, 0);
        tx_valid = 1'b0;
        repeat (5) @(negedge clk_42);

        // Re-enable: full leader again, and neither held nor ignored byte appears.
        enable = 1'b1;
        @(negedge clk_42);
        chk("re_leader", leader_active, 1);
        expect_bits("re_leader", 1, 16'b1);
        chk("re_lead_mid", leader_active, 1);
        expect_bits("re_leader", 1, 16'b1);
        chk("re_lead_end", leader_active, 0);
        expect_bits("hold_gone", 2, 16'b11);
        chk("re_ready", tx_ready, 1);

        // Reset while running.
        repeat (37) @(negedge clk_42);
        reset = 1'b1;
        @(negedge clk_42);
        chk("mrst_cas", cas_out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", tx_ready, 0);
        reset = 1'b0;
        @(negedge clk_42);
        chk("mrst_leader", leader_active, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
